// File: rtl/prio_pkg.sv
// prio_pkg: shared mode encodings for the priority encoder/arbiter
package prio_pkg;
  localparam logic PRIO_MODE_FIXED = 1'b0;
  localparam logic PRIO_MODE_RR = 1'b1;
endpackage

// File: rtl/prio_enc_rr_if.sv
// prio_enc_rr_if: request side and registered grant side of the arbiter
interface prio_enc_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);
  logic mode;
  logic [N-1:0] req;
  logic out_ready;
  logic out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic busy_any;
  modport master (output mode, req, out_ready, input out_valid, out_idx, out_onehot, busy_any);
  modport slave (input mode, req, out_ready, output out_valid, out_idx, out_onehot, busy_any);
endinterface

// File: rtl/prio_enc_core.sv
// prio_enc_core: combinational highest-set-index encoder
module prio_enc_core #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic o_found
);
  // later (higher) indices overwrite earlier ones, so the top set bit wins
  always_comb begin
    o_idx = '0;
    o_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) begin
        o_idx = W'(i);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/prio_enc_rr.sv
// prio_enc_rr: registered fixed/round-robin priority arbiter with valid/ready output
module prio_enc_rr
  import prio_pkg::*;
#(
  parameter int N = 8
) (
  input logic clk,
  input logic rst,
  prio_enc_rr_if.slave bus
);
  localparam int W = $clog2(N);
  localparam logic [W:0] NW = (W+1)'(N);
  logic r_valid;
  logic [W-1:0] r_idx;
  logic [W-1:0] r_ptr;
  logic [N-1:0] r_onehot;
  logic w_rr;
  logic w_load;
  logic w_found;
  logic [W-1:0] w_amt;
  logic [W:0] w_back;
  logic [N-1:0] w_rot;
  logic [W-1:0] w_cidx;
  logic [W:0] w_sum;
  logic [W-1:0] w_win;
  assign w_rr = bus.mode == PRIO_MODE_RR;
  assign w_load = !r_valid || bus.out_ready;
  assign w_amt = w_rr ? r_ptr : '0;
  assign w_back = NW - {1'b0, w_amt};
  assign w_rot = (bus.req >> w_amt) | (bus.req << w_back);
  prio_enc_core #(.N(N)) u_core (
    .i_req(w_rot),
    .o_idx(w_cidx),
    .o_found(w_found)
  );
  assign w_sum = {1'b0, w_cidx} + {1'b0, w_amt};
  assign w_win = w_sum >= NW ? W'(w_sum - NW) : w_sum[W-1:0];
  // take a new grant whenever the output slot is empty or being consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx <= '0;
      r_onehot <= '0;
      r_ptr <= '0;
    end else if (w_load) begin
      r_valid <= w_found;
      r_idx <= w_found ? w_win : '0;
      r_onehot <= w_found ? N'(1) << w_win : '0;
      r_ptr <= w_found && w_rr ? w_win : r_ptr;
    end
  end
  assign bus.out_valid = r_valid;
  assign bus.out_idx = r_idx;
  assign bus.out_onehot = r_onehot;
  assign bus.busy_any = |bus.req;
endmodule
